// File: rtl/ign_sched.sv
// ign_sched: per-tooth ignition scheduler, converting spark phases into cycle delays on two shared timers.
// Ports: clk/reset_n (sync, active-low); trigger pulses once per crank tooth with eng_phase,
// next_tooth_width and tooth_period describing the tooth; timing0..3 give the spark phase per channel.
// spark is a one-cycle pulse per channel, busy is high while scanning, overrun flags an ignored
// trigger, and drop/drop_cnt record events lost for lack of a free timer.
module ign_sched #(
  parameter int NCH = 4,
  parameter int MARGIN = 20,
  parameter int LAT_COMP = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           trigger,
  input  logic [15:0]    eng_phase,
  input  logic [15:0]    next_tooth_width,
  input  logic [31:0]    tooth_period,
  input  logic [15:0]    timing0,
  input  logic [15:0]    timing1,
  input  logic [15:0]    timing2,
  input  logic [15:0]    timing3,
  output logic [NCH-1:0] spark,
  output logic           busy,
  output logic           overrun,
  output logic           drop,
  output logic [7:0]     drop_cnt
);
  typedef enum logic [1:0] {IDLE, SCAN, MUL, LOAD} state_t;
  state_t      state;
  logic [1:0]  ch;
  logic [15:0] ph, ntw, q, tim;
  logic [31:0] per, pd, dly;
  // product bits above 38 never reach the delay, so the accumulator stops there
  logic [38:0] acc, mc;
  logic [3:0]  mcnt;
  logic [1:0]  t_act;
  logic [31:0] t_cnt [2];
  logic [1:0]  t_ch [2];
  logic [16:0] lim;
  logic        held, qual, last;
  logic [NCH-1:0] spark_nxt;
  always_comb begin
    tim = ch == 2'd0 ? timing0 : ch == 2'd1 ? timing1 : ch == 2'd2 ? timing2 : timing3;
    lim = {1'b0, ph} + {1'b0, ntw} + 17'(MARGIN);
    held = (t_act[0] && t_ch[0] == ch) || (t_act[1] && t_ch[1] == ch);
    qual = tim > ph && {1'b0, tim} <= lim && !held;
    last = ch == 2'd3;
    pd = acc[38:7];
    dly = pd < 32'(LAT_COMP) ? 32'd0 : pd - 32'(LAT_COMP);
    busy = state != IDLE;
    spark_nxt = '0;
    for (int k = 0; k < NCH; k++)
      spark_nxt[k] = (t_act[0] && t_cnt[0] == 32'd0 && t_ch[0] == 2'(k)) ||
                     (t_act[1] && t_cnt[1] == 32'd0 && t_ch[1] == 2'(k));
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ch <= '0;
      ph <= '0;
      ntw <= '0;
      per <= '0;
      q <= '0;
      acc <= '0;
      mc <= '0;
      mcnt <= '0;
      t_act <= '0;
      for (int i = 0; i < 2; i++) begin
        t_cnt[i] <= '0;
        t_ch[i] <= '0;
      end
      spark <= '0;
      overrun <= 1'b0;
      drop <= 1'b0;
      drop_cnt <= '0;
    end else begin
      overrun <= trigger && state != IDLE;
      spark <= spark_nxt;
      for (int i = 0; i < 2; i++)
        if (t_act[i]) begin
          if (t_cnt[i] == 32'd0) t_act[i] <= 1'b0;
          else t_cnt[i] <= t_cnt[i] - 32'd1;
        end
      case (state)
        IDLE: if (trigger) begin
          ph <= eng_phase;
          ntw <= next_tooth_width;
          per <= tooth_period;
          ch <= '0;
          state <= SCAN;
        end
        SCAN: if (qual) begin
          q <= tim - ph;
          acc <= '0;
          mc <= {7'd0, per};
          mcnt <= '0;
          state <= MUL;
        end else begin
          ch <= ch + 2'd1;
          state <= last ? IDLE : SCAN;
        end
        MUL: begin
          acc <= acc + (q[0] ? mc : 39'd0);
          mc <= mc << 1;
          q <= q >> 1;
          mcnt <= mcnt + 4'd1;
          if (mcnt == 4'd15) state <= LOAD;
        end
        LOAD: begin
          // free status is taken before this edge's expiries, so an expiring timer is not reused
          if (!t_act[0]) begin
            t_act[0] <= 1'b1;
            t_cnt[0] <= dly;
            t_ch[0] <= ch;
          end else if (!t_act[1]) begin
            t_act[1] <= 1'b1;
            t_cnt[1] <= dly;
            t_ch[1] <= ch;
          end else begin
            drop <= 1'b1;
            if (drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
          end
          ch <= ch + 2'd1;
          state <= last ? IDLE : SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ign_sched.sv
// tb_ign_sched: scoreboard bench predicting spark channel and cycle for each trigger.
module tb_ign_sched;
  localparam int MARGIN = 20;
  localparam int LAT = 4;
  logic clk = 1'b0, reset_n = 1'b0, trigger = 1'b0;
  logic [15:0] eng_phase = '0, next_tooth_width = '0;
  logic [15:0] timing0 = '0, timing1 = '0, timing2 = '0, timing3 = '0;
  logic [31:0] tooth_period = '0;
  logic [3:0] spark;
  logic busy, overrun, drop;
  logic [7:0] drop_cnt;

  ign_sched #(.NCH(4), .MARGIN(MARGIN), .LAT_COMP(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .eng_phase(eng_phase),
    .next_tooth_width(next_tooth_width), .tooth_period(tooth_period),
    .timing0(timing0), .timing1(timing1), .timing2(timing2), .timing3(timing3),
    .spark(spark), .busy(busy), .overrun(overrun), .drop(drop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {longint ch; longint at;} ev_t;
  ev_t sb[$];
  longint cyc = 0;
  longint tm_exp[2] = '{0, 0};
  longint tm_ch[2] = '{0, 0};
  int n_chk = 0, n_fail = 0, n_ovr = 0, exp_drops = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic void push_ev(input longint ch, input longint at);
    ev_t e;
    int i = 0;
    while (i < sb.size() && (sb[i].at < at || (sb[i].at == at && sb[i].ch < ch))) i++;
    e.ch = ch;
    e.at = at;
    sb.insert(i, e);
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (overrun) n_ovr++;
    for (int k = 0; k < 4; k++)
      if (spark[k]) begin
        if (sb.size() == 0) check("spark_unexpected", k, -1);
        else begin
          e = sb.pop_front();
          check("spark_ch", k, e.ch);
          check("spark_cycle", cyc, e.at);
        end
      end
  end

  // Drive one trigger and predict its events: edge t enters SCAN, each scan
  // takes one edge, a qualified channel adds 16 MUL edges plus the LOAD edge.
  task automatic fire(input logic [15:0] ph, input logic [15:0] ntw, input logic [31:0] per,
                      input logic [15:0] t0, input logic [15:0] t1,
                      input logic [15:0] t2, input logic [15:0] t3);
    logic [15:0] tm[4];
    longint t, s, ld, p, pd, d;
    logic [15:0] q;
    bit held, found;
    tm = '{t0, t1, t2, t3};
    @(negedge clk);
    eng_phase = ph;
    next_tooth_width = ntw;
    tooth_period = per;
    timing0 = t0;
    timing1 = t1;
    timing2 = t2;
    timing3 = t3;
    trigger = 1'b1;
    t = cyc + 1;
    for (int c = 0; c < 4; c++) begin
      s = t + 1;
      held = 0;
      for (int j = 0; j < 2; j++) if (tm_exp[j] > s - 1 && tm_ch[j] == c) held = 1;
      if (tm[c] > ph && 17'(tm[c]) <= 17'(ph) + 17'(ntw) + 17'(MARGIN) && !held) begin
        ld = s + 17;
        q = tm[c] - ph;
        p = longint'(per) * longint'(q);
        pd = (p >> 7) & 64'hffff_ffff;
        d = pd < LAT ? 0 : pd - LAT;
        found = 0;
        for (int j = 0; j < 2; j++)
          if (!found && tm_exp[j] <= ld - 1) begin
            found = 1;
            tm_exp[j] = ld + d + 1;
            tm_ch[j] = c;
            push_ev(c, ld + d + 1);
          end
        if (!found) exp_drops++;
        t = ld;
      end else t = s;
    end
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) return;
    end
    check("timeout", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_spark", spark, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_drop", drop, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    fire(100, 50, 1280, 110, 0, 0, 0);
    check("scan_busy", busy, 1);
    wait_done(400);
    check("single_drop", drop, 0);

    fire(100, 50, 1280, 110, 130, 140, 0);
    wait_done(600);
    check("drop_flag", drop, 1);
    check("drop_cnt", drop_cnt, 1);
    check("drop_model", exp_drops, 1);

    fire(100, 50, 1280, 170, 0, 0, 0);
    wait_done(1000);
    fire(100, 50, 1280, 171, 0, 0, 0);
    wait_done(400);
    fire(100, 50, 1280, 100, 0, 0, 0);
    wait_done(400);
    check("edge_drop_cnt", drop_cnt, 1);

    fire(100, 50, 10, 101, 0, 0, 0);
    wait_done(200);

    check("ovr_before", n_ovr, 0);
    fire(100, 50, 1280, 110, 0, 0, 0);
    repeat (2) @(negedge clk);
    eng_phase = 16'd0;
    tooth_period = 32'd5000;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_done(400);
    check("ovr_count", n_ovr, 1);
    check("ovr_sticky_drop", drop, 1);

    fire(100, 50, 1280, 110, 130, 0, 0);
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("armed_busy", busy, 0);
    check("armed_pending", sb.size(), 2);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    tm_exp = '{0, 0};
    check("post_rst_busy", busy, 0);
    check("post_rst_drop", drop, 0);
    check("post_rst_drop_cnt", drop_cnt, 0);
    repeat (400) @(negedge clk);
    check("post_rst_quiet", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
